// File: rtl/pipe_decoder.sv
// Registered binary-to-one-hot decoder with single-shot decode and a
// self-timed sweep over every index, one beat per cycle.
module pipe_decoder #(
   parameter int IN_W      = 5,
   parameter int OUT_W     = 2**IN_W,
   parameter bit MASK_ZERO = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [IN_W-1:0]  in,
   input  logic             sweep_start,
   output logic [OUT_W-1:0] out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t             state_q, state_d;
   logic [IN_W-1:0]    cnt_q, cnt_d;
   logic [OUT_W-1:0]   out_q, out_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // sweep_start wins; a coincident en is dropped, not queued
            if (sweep_start) begin
               state_d = SWEEP;
               cnt_d   = '0;
            end else if (en) begin
               out_d[in] = 1'b1;
               valid_d   = 1'b1;
            end
         end
         SWEEP: begin
            out_d[cnt_q] = 1'b1;
            valid_d      = 1'b1;
            busy_d       = 1'b1;
            if (cnt_q == '1) begin
               done_d  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (MASK_ZERO) out_d[0] = 1'b0;
   end

   assign out       = out_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pipe_decoder.sv
// Directed self-checking bench: default 5-bit decoder plus a 2-bit
// instance with index 0 masked.
module tb_pipe_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en, sweep_start;
   logic [4:0]  in;
   logic [31:0] out;
   logic        out_valid, busy, done;

   logic        en2, sw2;
   logic [1:0]  in2;
   logic [3:0]  out2;
   logic        valid2, busy2, done2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_decoder #(.IN_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in), .sweep_start(sweep_start),
      .out(out), .out_valid(out_valid), .busy(busy), .done(done)
   );

   pipe_decoder #(.IN_W(2), .MASK_ZERO(1'b1)) dut_m (
      .clk(clk), .rst_n(rst_n), .en(en2), .in(in2), .sweep_start(sw2),
      .out(out2), .out_valid(valid2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_main(input string tag, input logic [31:0] o, input logic v,
                           input logic b, input logic d);
      chk({tag, ".out"},   out, o);
      chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
      chk({tag, ".busy"},  {31'b0, busy}, {31'b0, b});
      chk({tag, ".done"},  {31'b0, done}, {31'b0, d});
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; in = '0; sweep_start = 1'b0;
      en2 = 1'b0; in2 = '0; sw2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_main("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_main("post_reset_idle", 32'h0, 1'b0, 1'b0, 1'b0);

      // single decode
      en = 1'b1; in = 5'd19;
      tick();
      chk_main("single", 32'h0008_0000, 1'b1, 1'b0, 1'b0);
      en = 1'b0;
      tick();
      chk_main("single_off", 32'h0, 1'b0, 1'b0, 1'b0);

      // back-to-back decode
      en = 1'b1; in = 5'd0;
      tick(); chk_main("b2b0", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
      in = 5'd1;
      tick(); chk_main("b2b1", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
      in = 5'd31;
      tick(); chk_main("b2b31", 32'h8000_0000, 1'b1, 1'b0, 1'b0);
      en = 1'b0;

      // full sweep with en pulses that must be ignored
      sweep_start = 1'b1;
      tick();
      chk_main("sweep_launch", 32'h0, 1'b0, 1'b0, 1'b0);
      sweep_start = 1'b0;
      for (int k = 0; k < 32; k++) begin
         en = k[0]; in = 5'd7; sweep_start = (k == 5);
         tick();
         chk_main($sformatf("sweep%0d", k), 32'h1 << k, 1'b1, 1'b1, k == 31);
      end
      en = 1'b1; in = 5'd3; sweep_start = 1'b0;
      tick();
      chk_main("after_sweep_en", 32'h0000_0008, 1'b1, 1'b0, 1'b0);
      en = 1'b0;
      tick();
      chk_main("after_sweep_idle", 32'h0, 1'b0, 1'b0, 1'b0);

      // sweep_start beats en; then reset at beat 10
      sweep_start = 1'b1; en = 1'b1; in = 5'd7;
      tick();
      chk_main("prio_launch", 32'h0, 1'b0, 1'b0, 1'b0);
      sweep_start = 1'b0; en = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         tick();
         chk_main($sformatf("prio%0d", k), 32'h1 << k, 1'b1, 1'b1, 1'b0);
      end
      rst_n = 1'b0;
      #1;
      chk_main("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_main("in_reset", 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_main("reset_released", 32'h0, 1'b0, 1'b0, 1'b0);
      en = 1'b1; in = 5'd3;
      tick();
      chk_main("post_abort_en", 32'h0000_0008, 1'b1, 1'b0, 1'b0);
      en = 1'b0;

      // masked 2-bit instance
      en2 = 1'b1; in2 = 2'd0;
      tick();
      chk("mask.en0.out", {28'b0, out2}, 32'h0);
      chk("mask.en0.valid", {31'b0, valid2}, 32'h1);
      in2 = 2'd2;
      tick();
      chk("mask.en2.out", {28'b0, out2}, 32'h4);
      en2 = 1'b0; sw2 = 1'b1;
      tick();
      chk("mask.launch.valid", {31'b0, valid2}, 32'h0);
      sw2 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("mask.sweep%0d.out", k), {28'b0, out2}, (k == 0) ? 32'h0 : (32'h1 << k));
         chk($sformatf("mask.sweep%0d.valid", k), {31'b0, valid2}, 32'h1);
         chk($sformatf("mask.sweep%0d.busy", k), {31'b0, busy2}, 32'h1);
         chk($sformatf("mask.sweep%0d.done", k), {31'b0, done2}, (k == 3) ? 32'h1 : 32'h0);
      end
      tick();
      chk("mask.idle.busy", {31'b0, busy2}, 32'h0);
      chk("mask.idle.done", {31'b0, done2}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
